pattern_tx_serializer: RTL and testbench
========================================

Name: pattern_tx_serializer

Overview:
- Transmit-side counterpart to the team's serial pattern recogniser FSMs.
- Accepts a parallel pattern word and repeat count, then shifts the word out MSB-first, one bit per clock, on a single serial line with a valid qualifier.
- The serial line feeds the recogniser's single-bit input for stimulus and loopback.
- Supports repeated transmission with programmable idle gaps, abort, and a one-cycle completion pulse.

Parameters:
- WIDTH, 8, pattern word width in bits (≥2).
- GAP, 2, idle cycles inserted between repeats (0 = back-to-back).
- RW, 4, width of the repeat-count input.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  request to start a transmission; accepted only when ready=1.
- data  input  WIDTH  pattern word, sampled on accepted load.
- count  input  RW  number of transmissions, sampled on accepted load; 0 is treated as 1.
- abort  input  1  synchronous cancel of any transmission in progress.
- ready  output  1  block idle and able to accept load.
- out  output  1  serial data bit (to recogniser input).
- out_valid  output  1  out carries a pattern bit this cycle.
- done  output  1  one-cycle pulse after the last bit of the last repeat.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ready=1, out=0, out_valid=0, done=0, shift register, held copy and counters cleared.
- All outputs are registered. out=0 whenever out_valid=0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - ready=1.
  - load=1 at edge k: capture data into the shift register and a held copy. reps = (count==0 ? 1 : count). bit_cnt = WIDTH-1. Go to SHIFT.
  - Ready drops after edge k.
- SHIFT:
  - out_valid=1, out = shift register MSB.
  - First bit (data[WIDTH-1]) is visible in the cycle after edge k; latency is 1 cycle.
  - Each edge shifts left by one and decrements bit_cnt.
  - On the edge where bit_cnt==0:
    - reps>1: decrement reps, reload the shift register from the held copy, bit_cnt=WIDTH-1, next state GAP (or SHIFT directly if GAP==0, giving a seamless bit stream).
    - reps==1: next state DONE.
- GAP: out_valid=0, out=0 for exactly GAP cycles (gap counter), then SHIFT.
- DONE: done=1, ready=0, out_valid=0 for one cycle, then IDLE (ready=1 the following cycle).
- Total out_valid cycles per transmission = WIDTH*reps. Total gap cycles = GAP*(reps-1).
- load while ready=0: ignored; data and count are not sampled.
- abort=1 in SHIFT or GAP:
  - Next state IDLE.
  - out_valid=0 and ready=1 from the next cycle; no done pulse.
  - abort has priority over the bit_cnt==0 transition.
- abort in IDLE or DONE: no effect. DONE still completes and done still pulses.
- load and abort both asserted in IDLE: load is accepted (abort is ignored in IDLE).
- Reset mid-transmission: immediate return to reset values; no done pulse; the partial pattern is discarded.
- data or count changing after acceptance has no effect on the transmission in progress.

Test Plan:
- Reset then idle: after rst_n release, ready=1, out_valid=0, done=0; load=0 for 10 cycles gives no change.
- Single pattern: WIDTH=8, data=8'hB4, count=1, load for 1 cycle -> out_valid high for exactly 8 cycles starting 1 cycle after accept, out sequence 1,0,1,1,0,1,0,0; done pulses the cycle after the last bit; ready=1 the next cycle.
- Repeat with gap: data=8'hB4, count=3, GAP=2 -> three 8-bit bursts separated by 2 cycles of out_valid=0/out=0; done once after the third burst; total 24 valid cycles.
- count=0 and load-while-busy: count=0 sends the word once; a second load with data=8'hFF during SHIFT is ignored and the bit stream stays 8'hB4.
- Abort: abort asserted in the 4th bit of a count=2 run -> out_valid=0 and ready=1 next cycle, no done pulse; a new load immediately after is accepted normally.
- Async reset mid-GAP: rst_n pulsed low between clock edges -> outputs go to reset values without waiting for clk; no done pulse; the block restarts cleanly on the next load.

Source files
------------

// File: rtl/pattern_tx_serializer.sv
// Serial pattern transmitter: shifts a captured word out MSB-first, repeated with idle gaps.
// Latency: first bit on out one cycle after an accepted load; all outputs registered.
// Backpressure: load is honoured only while ready=1; abort cancels SHIFT/GAP with no done pulse.
module pattern_tx_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int RW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [RW-1:0]    count,
  input  logic             abort,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  // Gap counter loads GAP-1 so the GAP state lasts exactly GAP cycles.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] held, held_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [RW-1:0]    reps, reps_d;
  logic [GW-1:0]    gap_cnt, gap_cnt_d;
  logic             out_d, out_valid_d, ready_d, done_d;

  // State and datapath registers, plus the registered copies of every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      held      <= '0;
      bit_cnt   <= '0;
      reps      <= '0;
      gap_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      held      <= held_d;
      bit_cnt   <= bit_cnt_d;
      reps      <= reps_d;
      gap_cnt   <= gap_cnt_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      ready     <= ready_d;
      done      <= done_d;
    end
  end

  // Next state and next datapath values; abort outranks the end-of-word decision.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    held_d    = held;
    bit_cnt_d = bit_cnt;
    reps_d    = reps;
    gap_cnt_d = gap_cnt;
    case (state)
      S_IDLE: begin
        if (load) begin
          shreg_d   = data;
          held_d    = data;
          reps_d    = (count == '0) ? RW'(1) : count;
          bit_cnt_d = BIT_LAST;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt == '0) begin
          if (reps > RW'(1)) begin
            reps_d    = reps - RW'(1);
            shreg_d   = held;
            bit_cnt_d = BIT_LAST;
            if (GAP == 0) begin
              state_d = S_SHIFT;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_LAST;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          shreg_d   = shreg << 1;
          bit_cnt_d = bit_cnt - BW'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt == '0) begin
          state_d = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt - GW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so they can be registered.
  always_comb begin
    out_valid_d = (state_d == S_SHIFT);
    out_d       = (state_d == S_SHIFT) && shreg_d[WIDTH-1];
    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_pattern_tx_serializer.sv
// Bench for pattern_tx_serializer: directed and random transmissions against a per-cycle model.
// Model builds the expected bit/valid/done/ready stream from word, repeat count, gap and abort point.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pattern_tx_serializer;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int RW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] data;
  logic [RW-1:0]    count;
  logic             abort;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             done;

  int checks   = 0;
  int failures = 0;

  pattern_tx_serializer #(.WIDTH(WIDTH), .GAP(GAP), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (data),
    .count     (count),
    .abort     (abort),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles one transmission occupies from the first bit up to and including the idle cycle after done.
  function automatic int full_len(input logic [RW-1:0] c);
    int r;
    r = (c == 0) ? 1 : int'(c);
    return r * WIDTH + GAP * (r - 1) + 2;
  endfunction

  // One transmission. abort_at: stream cycle during which abort is held (-1 none).
  // busy_at: stream cycle during which a competing load (data=FF) is driven (-1 none).
  task automatic run_tx(input string name, input logic [WIDTH-1:0] d, input logic [RW-1:0] c,
                        input int abort_at, input bit abort_with_load, input int busy_at);
    bit ev[$];
    bit eo[$];
    bit ed[$];
    bit er[$];
    int reps;
    int len;
    int nv_obs;
    int nv_exp;
    reps = (c == 0) ? 1 : int'(c);
    for (int r = 0; r < reps; r++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        ev.push_back(1'b1); eo.push_back(d[i]); ed.push_back(1'b0); er.push_back(1'b0);
      end
      if (r < reps - 1) begin
        for (int g = 0; g < GAP; g++) begin
          ev.push_back(1'b0); eo.push_back(1'b0); ed.push_back(1'b0); er.push_back(1'b0);
        end
      end
    end
    ev.push_back(1'b0); eo.push_back(1'b0); ed.push_back(1'b1); er.push_back(1'b0);
    ev.push_back(1'b0); eo.push_back(1'b0); ed.push_back(1'b0); er.push_back(1'b1);
    // An abort before the done cycle ends the stream; the following cycle is plain idle.
    if (abort_at >= 0 && abort_at < ev.size() - 2) begin
      while (ev.size() > abort_at + 1) begin
        void'(ev.pop_back()); void'(eo.pop_back()); void'(ed.pop_back()); void'(er.pop_back());
      end
      ev.push_back(1'b0); eo.push_back(1'b0); ed.push_back(1'b0); er.push_back(1'b1);
    end
    len = ev.size();
    nv_exp = 0;
    foreach (ev[i]) nv_exp += int'(ev[i]);
    nv_obs = 0;

    @(negedge clk);
    check($sformatf("%s ready_before_load", name), int'(ready), 1);
    load = 1'b1; data = d; count = c; abort = abort_with_load;
    for (int cyc = 0; cyc < len; cyc++) begin
      @(negedge clk);
      check($sformatf("%s out_valid[%0d]", name, cyc), int'(out_valid), int'(ev[cyc]));
      check($sformatf("%s out[%0d]", name, cyc), int'(out), int'(eo[cyc]));
      check($sformatf("%s done[%0d]", name, cyc), int'(done), int'(ed[cyc]));
      check($sformatf("%s ready[%0d]", name, cyc), int'(ready), int'(er[cyc]));
      nv_obs += int'(out_valid);
      // Scramble the inputs after acceptance; the transmission must not notice.
      data  = WIDTH'($urandom);
      count = RW'($urandom);
      abort = (cyc == abort_at);
      if (cyc == busy_at && cyc < len - 1) begin
        load = 1'b1; data = 8'hFF; count = 4'd5;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0; abort = 1'b0;
    check($sformatf("%s valid_cycles", name), nv_obs, nv_exp);
    // Nothing may start on its own afterwards (e.g. from a load that should have been ignored).
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("%s idle_valid[%0d]", name, k), int'(out_valid), 0);
      check($sformatf("%s idle_ready[%0d]", name, k), int'(ready), 1);
      check($sformatf("%s idle_done[%0d]", name, k), int'(done), 0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic [RW-1:0]    rc;
    int               ab;

    rst_n = 1'b0; load = 1'b0; data = '0; count = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", int'(ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out", int'(out), 0);
    check("reset done", int'(done), 0);
    #2 rst_n = 1'b1;

    // Idle with no load: nothing changes for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle ready[%0d]", k), int'(ready), 1);
      check($sformatf("idle out_valid[%0d]", k), int'(out_valid), 0);
      check($sformatf("idle done[%0d]", k), int'(done), 0);
    end

    run_tx("single",    8'hB4, 4'd1, -1, 1'b0, -1);
    run_tx("repeat3",   8'hB4, 4'd3, -1, 1'b0, -1);
    run_tx("cnt0_busy", 8'hB4, 4'd0, -1, 1'b0, 2);
    run_tx("busy_done", 8'h3C, 4'd1, -1, 1'b0, 8);
    run_tx("abort4",    8'hB4, 4'd2, 3, 1'b0, -1);
    run_tx("after_abt", 8'h96, 4'd1, -1, 1'b0, -1);
    run_tx("load_abt",  8'hC3, 4'd2, -1, 1'b1, -1);
    run_tx("abort_gap", 8'h5A, 4'd2, 9, 1'b0, -1);
    run_tx("abort_dn",  8'hE1, 4'd1, 8, 1'b0, -1);

    // Asynchronous reset while in the gap between repeats.
    @(negedge clk);
    load = 1'b1; data = 8'hB4; count = 4'd3;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    check("arst pre out_valid", int'(out_valid), 0);
    check("arst pre ready", int'(ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst ready", int'(ready), 1);
    check("arst out_valid", int'(out_valid), 0);
    check("arst out", int'(out), 0);
    check("arst done", int'(done), 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("arst after done[%0d]", k), int'(done), 0);
      check($sformatf("arst after valid[%0d]", k), int'(out_valid), 0);
      check($sformatf("arst after ready[%0d]", k), int'(ready), 1);
    end
    run_tx("post_arst", 8'hB4, 4'd1, -1, 1'b0, -1);

    // Random words, counts and occasional aborts anywhere up to the done cycle.
    for (int t = 0; t < 10; t++) begin
      rd = WIDTH'($urandom);
      rc = RW'($urandom_range(0, 4));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, full_len(rc) - 2)) : -1;
      run_tx($sformatf("rand%0d", t), rd, rc, ab, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
